// File: rtl/mmio_io_pkg.sv
// mmio_io_hub shared definitions: register offsets
// and the active-low hex-to-segment table.
package mmio_io_pkg;

  localparam logic [11:0] DIG_OFS      = 12'h000;
  localparam logic [11:0] DIG_MASK_OFS = 12'h004;
  localparam logic [11:0] LED_OFS      = 12'h060;
  localparam logic [11:0] SW_OFS       = 12'h070;
  localparam logic [11:0] BTN_OFS      = 12'h078;
  localparam logic [11:0] BTN_EDGE_OFS = 12'h07C;

  // {DP,G,F,E,D,C,B,A}, low = lit
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/io_debounce.sv
// 2-FF synchroniser plus tick-sampled debouncer:
// output moves only when two consecutive samples agree.
module io_debounce
  import mmio_io_pkg::*;
#(
  parameter int W          = 1,
  parameter int DEB_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic [W-1:0]  s1, s2, smp;
  logic [W-1:0]  agree;
  logic [CW-1:0] cnt;
  logic          tick;

  assign tick  = (cnt == LAST);
  assign agree = ~(s2 ^ smp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      smp  <= '0;
      dout <= '0;
      cnt  <= '0;
    end else begin
      s1  <= din;
      s2  <= s1;
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        smp  <= s2;
        dout <= (dout & ~agree) | (s2 & agree);
      end
    end
  end

endmodule

// File: rtl/mmio_io_hub.sv
// Memory-mapped display / LED / switch / button hub
// with digit mask and sticky button edge capture.
module mmio_io_hub
  import mmio_io_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int LED_W      = 24,
  parameter int SW_W       = 24,
  parameter int BTN_W      = 5,
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_CYCLES = 200000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           addr,
  input  logic                  wen,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  input  logic [SW_W-1:0]       switch,
  input  logic [BTN_W-1:0]      button,
  output logic [LED_W-1:0]      led,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic [7:0]            seg
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(SCAN_DIV - 1);

  logic [DW-1:0]         dig_q;
  logic [NUM_DIGITS-1:0] mask_q;
  logic [LED_W-1:0]      led_q;
  logic [BTN_W-1:0]      edge_q;
  logic [BTN_W-1:0]      btn_prev;
  logic [SW_W-1:0]       sw_deb;
  logic [BTN_W-1:0]      btn_deb;
  logic [BTN_W-1:0]      rise;
  logic [BTN_W-1:0]      clr;
  logic [CW-1:0]         scan_cnt;
  logic [IW-1:0]         digit_idx;
  logic [3:0]            nib;

  logic wr_dig, wr_mask, wr_led, wr_edge;

  assign wr_dig  = wen && (addr == DIG_OFS);
  assign wr_mask = wen && (addr == DIG_MASK_OFS);
  assign wr_led  = wen && (addr == LED_OFS);
  assign wr_edge = wen && (addr == BTN_EDGE_OFS);

  io_debounce #(
    .W          (SW_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sw_deb (
    .clk   (clk),
    .rst_n (rst),
    .din   (switch),
    .dout  (sw_deb)
  );

  io_debounce #(
    .W          (BTN_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_deb (
    .clk   (clk),
    .rst_n (rst),
    .din   (button),
    .dout  (btn_deb)
  );

  assign rise = btn_deb & ~btn_prev;
  assign clr  = wr_edge ? wdata[BTN_W-1:0] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_q    <= '0;
      mask_q   <= '1;
      led_q    <= '0;
      edge_q   <= '0;
      btn_prev <= '0;
    end else begin
      if (wr_dig)  dig_q  <= wdata[DW-1:0];
      if (wr_mask) mask_q <= wdata[NUM_DIGITS-1:0];
      if (wr_led)  led_q  <= wdata[LED_W-1:0];
      btn_prev <= btn_deb;
      // set has priority over a same-cycle W1C
      edge_q   <= (edge_q & ~clr) | rise;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == C_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == I_LAST) ? '0
                 : digit_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  always_comb begin
    nib    = '0;
    dig_en = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        nib       = dig_q[4*i +: 4];
        dig_en[i] = ~mask_q[i];
      end
    end
  end

  assign seg = SEG_LUT[nib];
  assign led = led_q;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      addr == DIG_OFS:      rdata[DW-1:0]         = dig_q;
      addr == DIG_MASK_OFS: rdata[NUM_DIGITS-1:0] = mask_q;
      addr == LED_OFS:      rdata[LED_W-1:0]      = led_q;
      addr == SW_OFS:       rdata[SW_W-1:0]       = sw_deb;
      addr == BTN_OFS:      rdata[BTN_W-1:0]      = btn_deb;
      addr == BTN_EDGE_OFS: rdata[BTN_W-1:0]      = edge_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed bench for mmio_io_hub: register vectors,
// scan order, debounce, edge capture and reset.
module tb_mmio_io_hub;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [23:0] switch;
  logic [4:0]  button;
  logic [23:0] led;
  logic [3:0]  dig_en;
  logic [7:0]  seg;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mmio_io_hub #(
    .NUM_DIGITS (4),
    .LED_W      (24),
    .SW_W       (24),
    .BTN_W      (5),
    .SCAN_DIV   (4),
    .DEB_CYCLES (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wen    (wen),
    .wdata  (wdata),
    .rdata  (rdata),
    .switch (switch),
    .button (button),
    .led    (led),
    .dig_en (dig_en),
    .seg    (seg)
  );

  typedef struct {
    logic [11:0] waddr;
    logic [31:0] wd;
    logic [11:0] raddr;
    logic [31:0] exp_rd;
    logic [23:0] exp_led;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [11:0] a,
                    input logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wen   = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic rd(input logic [11:0] a,
                    output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic wait_rd(input logic [11:0] a,
                         input logic [31:0] m,
                         input logic [31:0] v,
                         input int budget,
                         output bit ok);
    logic [31:0] d;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      cyc();
      rd(a, d);
      if ((d & m) == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_regs(input string nm);
    logic [11:0] ra[6];
    logic [31:0] re[6];
    logic [31:0] d;
    ra = '{12'h000, 12'h004, 12'h060,
           12'h070, 12'h078, 12'h07C};
    re = '{32'h0, 32'hF, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      rd(ra[i], d);
      chk($sformatf("%s_reg%03h", nm, ra[i]), d, re[i]);
    end
  endtask

  logic [3:0]  en_t[4];
  logic [7:0]  sg_t[4];
  logic [31:0] d;
  bit          ok;
  int          di;

  initial begin
    vt[0] = '{12'h060, 32'hFFFF_FFFF, 12'h060, 32'h00FF_FFFF, 24'hFFFFFF};
    vt[1] = '{12'h100, 32'h1234_5678, 12'h100, 32'h0,         24'hFFFFFF};
    vt[2] = '{12'h070, 32'h0000_00FF, 12'h070, 32'h0,         24'hFFFFFF};
    vt[3] = '{12'h000, 32'hFFFF_FFFF, 12'h000, 32'h0000_FFFF, 24'hFFFFFF};
    vt[4] = '{12'h004, 32'hFFFF_FFF5, 12'h004, 32'h5,         24'hFFFFFF};
    vt[5] = '{12'h060, 32'h0012_3456, 12'h060, 32'h0012_3456, 24'h123456};
    vt[6] = '{12'h004, 32'h0000_000F, 12'h004, 32'hF,         24'h123456};
    vt[7] = '{12'h000, 32'h0000_1234, 12'h000, 32'h0000_1234, 24'h123456};

    en_t = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    sg_t = '{8'hF9, 8'h8E, 8'hB0, 8'h88};

    rst = 1'b0; addr = '0; wen = 1'b0; wdata = '0;
    switch = '0; button = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_dig_en", 32'(dig_en), 32'hE);
    chk("rst_seg", 32'(seg), 32'hC0);
    chk_regs("rst");
    rst = 1'b1;
    cyc();

    for (int i = 0; i < 8; i++) begin
      wr(vt[i].waddr, vt[i].wd);
      rd(vt[i].raddr, d);
      chk($sformatf("vec%0d_rd", i), d, vt[i].exp_rd);
      chk($sformatf("vec%0d_led", i), 32'(led), 32'(vt[i].exp_led));
    end

    switch = 24'h000005;
    wait_rd(12'h070, 32'hFFFF_FFFF, 32'h5, 9, ok);
    chk("sw_latency", 32'(ok), 32'h1);
    switch = 24'h000004;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) switch = 24'h000005;
      cyc();
      rd(12'h070, d);
      chk($sformatf("sw_glitch%0d", i), d, 32'h5);
    end

    button = 5'b00100;
    wait_rd(12'h078, 32'hFFFF_FFFF, 32'h4, 9, ok);
    chk("btn_rise", 32'(ok), 32'h1);
    rd(12'h07C, d);
    chk("edge_pre", d, 32'h0);
    cyc();
    rd(12'h07C, d);
    chk("edge_set", d, 32'h4);
    button = 5'b00000;
    wait_rd(12'h078, 32'hFFFF_FFFF, 32'h0, 9, ok);
    chk("btn_fall", 32'(ok), 32'h1);
    rd(12'h07C, d);
    chk("edge_sticky", d, 32'h4);
    wr(12'h07C, 32'h0000_0004);
    rd(12'h07C, d);
    chk("edge_w1c", d, 32'h0);

    button = 5'b00100;
    wait_rd(12'h078, 32'h4, 32'h4, 9, ok);
    chk("btn_rise2", 32'(ok), 32'h1);
    rd(12'h07C, d);
    chk("edge_pre2", d, 32'h0);
    wr(12'h07C, 32'h0000_0004);
    rd(12'h07C, d);
    chk("edge_collide", d, 32'h4);
    button = 5'b00000;

    #2 rst = 1'b0;
    #1;
    chk("mid_rst_led", 32'(led), 32'h0);
    chk("mid_rst_dig_en", 32'(dig_en), 32'hE);
    chk("mid_rst_seg", 32'(seg), 32'hC0);
    chk_regs("mid_rst");
    @(negedge clk);
    rst = 1'b1;

    wr(12'h000, 32'h0000_A3F1);
    for (int k = 0; k < 15; k++) begin
      di = (k + 1) / 4;
      chk($sformatf("scan%0d_en", k), 32'(dig_en), 32'(en_t[di]));
      chk($sformatf("scan%0d_seg", k), 32'(seg), 32'(sg_t[di]));
      if (k < 14) cyc();
    end
    wr(12'h004, 32'h0000_000A);
    for (int k = 0; k < 16; k++) begin
      di = k / 4;
      chk($sformatf("mask%0d_en", k), 32'(dig_en),
          (di == 0 || di == 2) ? 32'hF : 32'(en_t[di]));
      chk($sformatf("mask%0d_seg", k), 32'(seg), 32'(sg_t[di]));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mmio_io_hub.md
# mmio_io_hub

Parametrised memory-mapped I/O peripheral for the miniRV SoC. It sits behind the Bridge on the 12-bit peripheral address window and combines four functions in one register-mapped block: a multiplexed seven-segment display, an LED bank, debounced switches, and debounced buttons with sticky rising-edge capture. It generalises the fixed display/LED/switch/button wiring with configurable widths, digit count and scan and debounce rates, and adds a digit-enable mask and edge-event registers.

## Interface
- NUM_DIGITS, 8: number of scanned digits, range 1..8.
- LED_W, 24: LED count, range 1..32.
- SW_W, 24: switch count, range 1..32.
- BTN_W, 5: button count, range 1..32.
- SCAN_DIV, 50000: clk cycles each digit stays lit, ≥2.
- DEB_CYCLES, 200000: debounce sample period in clk cycles, ≥2.
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset.
- addr  in  12  register offset from the Bridge.
- wen  in  1  write strobe, sampled at posedge clk.
- wdata  in  32  write data.
- rdata  out  32  combinational read data for `addr`.
- switch  in  SW_W  raw switch pins, asynchronous.
- button  in  BTN_W  raw button pins, asynchronous.
- led  out  LED_W  LED drive, active-high.
- dig_en  out  NUM_DIGITS  digit select, active-low one-hot.
- seg  out  8  segments {DP,G,F,E,D,C,B,A}, active-low.

## Operation
Register map. Writes to read-only registers are ignored.
- 0x000 DIG (RW): nibble i, bits [4i+3:4i], is shown on digit i. Bits above 4·NUM_DIGITS read back 0.
- 0x004 DIG_MASK (RW, [NUM_DIGITS-1:0]): 1 enables digit i.
- 0x060 LED (RW, [LED_W-1:0]): drives `led` directly.
- 0x070 SW (RO): debounced switches, zero-extended.
- 0x078 BTN (RO): debounced buttons, zero-extended.
- 0x07C BTN_EDGE (RW1C): bit set on a debounced 0→1 of that button. Writing 1 to a bit clears it.
- Unmapped offsets read 0; writes to them are ignored.

Display:
- scan_cnt counts 0..SCAN_DIV-1. On its terminal count, digit_idx advances and wraps NUM_DIGITS-1 → 0.
- dig_en is ~(1<<digit_idx) when DIG_MASK[digit_idx]=1, otherwise all-ones, so the slot stays blank but still takes its time.
- seg is the hex decode of the current nibble: 0-9 and A-F. DP is always off (1).

Debounce:
- Each input passes through a 2-FF synchroniser.
- A shared tick counter pulses once every DEB_CYCLES cycles.
- On each tick the synchronised value is sampled. The debounced bit updates only when two consecutive samples agree.

Edge capture:
- When debounced BTN[i] rises, BTN_EDGE[i] is set.
- If a set and a W1C of the same bit occur in the same cycle, the set wins.

Reset values:
- DIG 0; DIG_MASK all-ones; LED 0; debounced SW, BTN and BTN_EDGE 0.
- scan_cnt, digit_idx and tick counter 0.
- Outputs after reset: led=0, dig_en=~1, seg=8'hC0 (shows "0").

## Timing
- Write: the register updates on the posedge clk where wen=1. rdata reflects the new value in the next cycle. Register outputs (led, seg source) follow one cycle after the write.
- Read: combinational, zero wait states, as the pipeline's MEM stage requires.
- Switch/button latency: a stable input change appears in SW/BTN 2 sync cycles plus 1 to 2 sample ticks later, i.e. at most 2 + 2·DEB_CYCLES + 1 cycles.
- A glitch shorter than DEB_CYCLES produces no change.
- BTN_EDGE sets one cycle after the debounced rise.
- Digit switches exactly every SCAN_DIV cycles. seg and dig_en change on the same edge, with no overlap cycle.
- Reset asserted mid-scan or mid-debounce returns everything to the reset values immediately, because reset is asynchronous. Counters restart from 0 after release.

## Structure
- Shared package `mmio_io_pkg`:
  - offsets DIG_OFS, DIG_MASK_OFS, LED_OFS, SW_OFS, BTN_OFS, BTN_EDGE_OFS;
  - the 16-entry active-low hex-to-segment constant table.
- Sub-module `io_debounce` #(W, DEB_CYCLES) contains the synchroniser, tick counter and two-sample agreement logic.
- It is instantiated twice, once for switches and once for buttons. Edge capture and the register file stay in the top.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, DEB_CYCLES=3.

- Reset check: assert rst=0 mid-run → led=0, dig_en=4'b1110, seg=8'hC0, and every register reads its reset value; release and confirm scan restarts at digit 0.
- Display scan: write DIG=32'h0000_A3F1 → over 16 cycles dig_en steps 1110, 1101, 1011, 0111 with seg 8'hF9 ("1"), 8'h8E ("F"), 8'hB0 ("3"), 8'h88 ("A"), each held 4 cycles. Then write DIG_MASK=4'b1010 → slots 0 and 2 show dig_en=4'b1111.
- LED and unmapped space: write LED=32'hFFFF_FFFF → led=24'hFFFFFF and reading 0x060 returns 32'h00FF_FFFF. A write to 0x100 changes nothing and a read of 0x100 returns 0.
- Switch debounce: drive switch=24'h00_0005 steady → SW reads 5 within 2+2·3+1 cycles. A 2-cycle pulse on switch[0] leaves SW unchanged.
- Button edge: hold button[2] high → BTN=5'b00100 and BTN_EDGE=5'b00100. Release → BTN=0 while BTN_EDGE stays set. Write 0x07C=32'h4 → BTN_EDGE=0.
- Set/clear collision: issue the W1C of bit 2 on the same cycle that the debounced button[2] rises → BTN_EDGE[2]=1 afterwards.
